pulse_gen_channel: RTL and testbench
====================================

Name: pulse_gen_channel

Overview:
- One step/PWM pulse-generator channel. Consumes the per-channel frequency word, the pulse-count load word and the start/stop strobes produced by the AHB register bridge.
- Returns the emitted-pulse count and a busy state to the bridge's read mux.
- Instantiated 16 times (channels 0–F), all in the clk100m domain; limit-switch inputs abort motion.

Parameters:
- CNT_W, 24, width of the target and emitted-pulse counters.
- MIN_HALF, 2, minimum half-period in clk100m cycles; smaller freq values are clamped to this.

Ports:
- clk100m  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- freq  in  32  half-period in clk100m cycles; level, held by the bridge.
- pnum  in  33  bit32 = one-cycle load strobe; [CNT_W-1:0] = target pulse count; bits 31:CNT_W ignored.
- start  in  1  one-cycle start strobe (pwm_start_stop bit i).
- stop  in  1  one-cycle stop strobe (pwm_start_stop bit i+16).
- limit  in  1  level, 1 = limit switch active (limit_l | limit_r for this channel).
- pulse_out  out  1  registered pulse output.
- busy  out  1  1 while generating; feeds the pwm_state_read bit.
- pnumcnt  out  CNT_W  completed pulses since the last start; feeds the pnumcnt read port.
- done  out  1  one-cycle pulse when the target is reached or motion aborts.

Behaviour:
- Reset, async on rst_n low:
  - pulse_out=0, busy=0, pnumcnt=0, done=0.
  - Target register=0, phase counter=0, state IDLE.
- Target load:
  - In IDLE, when pnum[32]=1, target <= pnum[CNT_W-1:0] at that edge.
  - Load is ignored while busy.
  - Target 0 = continuous mode.
- State machine IDLE -> HIGH -> LOW -> HIGH ... -> IDLE.
- IDLE:
  - If start=1 and stop=0 and limit=0: at that edge, state=HIGH, pulse_out=1, busy=1, pnumcnt=0, phase=1.
  - The half-period h = max(freq, MIN_HALF) is latched at the same edge.
  - Otherwise stay in IDLE.
- HIGH:
  - pulse_out=1 for exactly h cycles.
  - On the h-th cycle, pnumcnt increments.
  - If target≠0 and pnumcnt+1 == target: go to IDLE, pulse_out=0, busy=0, done=1 for one cycle.
  - Else go to LOW, pulse_out=0, phase=1.
- LOW:
  - pulse_out=0 for exactly h cycles, then go to HIGH.
  - h is re-latched from freq at entry to each HIGH, so frequency changes take effect on the next pulse and never mid-pulse.
- Period = 2h cycles; duty cycle 50%.
- pnumcnt wraps from all-ones to 0 in continuous mode; it holds its value in IDLE until the next start.
- Abort: stop=1 or limit=1 in HIGH/LOW.
  - Next edge: state=IDLE, pulse_out=0, busy=0, done=1.
  - pnumcnt is not incremented for a truncated HIGH phase.
- Simultaneous events:
  - start with stop: stop wins, no start.
  - start with limit: no start.
  - start while busy: ignored (no restart).
  - pnum load with start in the same IDLE cycle: the new target is used.
- done is asserted only on a busy->idle transition; it is never asserted from IDLE.
- Reset mid-operation: all outputs return to reset values immediately (async); the target is lost.

Test Plan:
- Reset, then pnum={1,32'd3}, freq=4, start pulse:
  - pulse_out shows 3 pulses, high 4 / low 4 cycles, starting the edge after the start strobe.
  - pnumcnt steps 1,2,3; done pulses once at the falling edge of the 3rd pulse; busy=0 afterwards.
- freq=0, target 2 -> half-period clamped to 2, period 4 cycles; pnumcnt=2 at end.
- Target 0, freq=2, 10 pulses, then stop mid-HIGH:
  - pulse_out=0 the next cycle; pnumcnt=10 (truncated pulse not counted); done=1; busy=0.
- Running with freq=3; change freq to 6 during a LOW phase:
  - The current LOW stays 3 cycles; the next HIGH and LOW are 6 cycles each.
- start and stop in the same cycle -> no motion, busy stays 0.
- limit=1 with start -> no motion.
- limit asserted while running -> abort as for stop.
- Running target 5; pnum load strobe with 100 mid-run -> ignored, run ends at 5.
- Running; rst_n low mid-HIGH -> pulse_out, busy and pnumcnt return to 0 asynchronously.

Source files
------------

// File: rtl/pulse_gen_channel_if.sv
// Bridge-to-channel bundle for one step/PWM pulse-generator channel.
// The bridge (master) drives the controls; the channel (slave) returns status.
interface pulse_gen_channel_if #(
    parameter int unsigned CNT_W = 24
);
    logic [31:0]      freq;
    logic [32:0]      pnum;
    logic             start;
    logic             stop;
    logic             limit;
    logic             pulse_out;
    logic             busy;
    logic [CNT_W-1:0] pnumcnt;
    logic             done;

    modport master (
        output freq, pnum, start, stop, limit,
        input  pulse_out, busy, pnumcnt, done
    );

    modport slave (
        input  freq, pnum, start, stop, limit,
        output pulse_out, busy, pnumcnt, done
    );
endinterface

// File: rtl/pulse_gen_channel.sv
// One step/PWM pulse-generator channel: emits 50% duty pulses of half-period
// max(freq, MIN_HALF), counts them, and stops at the target or on stop/limit.
module pulse_gen_channel #(
    parameter int unsigned CNT_W    = 24,
    parameter int unsigned MIN_HALF = 2
) (
    input  logic              clk100m,
    input  logic              rst_n,
    pulse_gen_channel_if.slave bus
);
    localparam int unsigned FREQ_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t            state;
    logic [FREQ_W-1:0] half_q;
    logic [FREQ_W-1:0] phase_q;
    logic [CNT_W-1:0]  target_q;
    logic [CNT_W-1:0]  pnumcnt_q;
    logic              pulse_q;
    logic              busy_q;
    logic              done_q;

    logic [FREQ_W-1:0] h_next;
    logic [CNT_W-1:0]  cnt_inc;
    logic              abort;
    logic              start_ok;

    // Half-period clamped to the minimum; sampled only at each HIGH entry.
    assign h_next   = (bus.freq < FREQ_W'(MIN_HALF)) ? FREQ_W'(MIN_HALF) : bus.freq;
    assign cnt_inc  = pnumcnt_q + CNT_W'(1);
    assign abort    = bus.stop | bus.limit;
    assign start_ok = bus.start & ~bus.stop & ~bus.limit;

    generate
        if (CNT_W < 32) begin : g_pnum_hi
            logic unused_pnum_hi;
            assign unused_pnum_hi = ^bus.pnum[31:CNT_W];
        end
    endgenerate

    always_ff @(posedge clk100m or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            half_q    <= '0;
            phase_q   <= '0;
            target_q  <= '0;
            pnumcnt_q <= '0;
            pulse_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.pnum[32]) begin
                        target_q <= bus.pnum[CNT_W-1:0];
                    end
                    if (start_ok) begin
                        state     <= HIGH;
                        pulse_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        pnumcnt_q <= '0;
                        phase_q   <= FREQ_W'(1);
                        half_q    <= h_next;
                    end
                end
                HIGH: begin
                    if (abort) begin
                        state   <= IDLE;
                        pulse_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (phase_q == half_q) begin
                        // Pulse completes here; counting happens only for full HIGH phases.
                        pnumcnt_q <= cnt_inc;
                        pulse_q   <= 1'b0;
                        if (target_q != '0 && cnt_inc == target_q) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            state   <= LOW;
                            phase_q <= FREQ_W'(1);
                        end
                    end else begin
                        phase_q <= phase_q + FREQ_W'(1);
                    end
                end
                LOW: begin
                    if (abort) begin
                        state   <= IDLE;
                        pulse_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (phase_q == half_q) begin
                        state   <= HIGH;
                        pulse_q <= 1'b1;
                        phase_q <= FREQ_W'(1);
                        half_q  <= h_next;
                    end else begin
                        phase_q <= phase_q + FREQ_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    pulse_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pulse_out = pulse_q;
    assign bus.busy      = busy_q;
    assign bus.pnumcnt   = pnumcnt_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_pulse_gen_channel.sv
// Directed + randomized bench for pulse_gen_channel; expected per-cycle outputs
// are built as a queue of samples from pulse-level rules (h high, h low, count).
module tb_pulse_gen_channel;
    localparam int unsigned CNT_W = 24;

    typedef struct {
        logic             p;
        logic             b;
        logic [CNT_W-1:0] c;
        logic             d;
    } samp_t;

    logic   clk100m;
    logic   rst_n;
    int     checks;
    int     failures;
    samp_t  q[$];

    pulse_gen_channel_if #(.CNT_W(CNT_W)) bus();

    pulse_gen_channel #(.CNT_W(CNT_W), .MIN_HALF(2)) dut (
        .clk100m (clk100m),
        .rst_n   (rst_n),
        .bus     (bus.slave)
    );

    initial clk100m = 1'b0;
    always #5 clk100m = ~clk100m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample point is 1 time unit later; strobes auto-clear.
    task automatic tick();
        @(posedge clk100m);
        #1;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.pnum[32] = 1'b0;
    endtask

    task automatic push(input logic p, input logic b, input int c, input logic d);
        samp_t s;
        s.p = p; s.b = b; s.c = CNT_W'(c); s.d = d;
        q.push_back(s);
    endtask

    task automatic push_high(input int h, input int c);
        for (int i = 0; i < h; i++) push(1'b1, 1'b1, c, 1'b0);
    endtask

    task automatic push_low(input int h, input int c);
        for (int i = 0; i < h; i++) push(1'b0, 1'b1, c, 1'b0);
    endtask

    // Full counted run of n pulses at constant half-period h, plus idle tail.
    task automatic push_run(input int h, input int n);
        for (int p = 0; p < n; p++) begin
            push_high(h, p);
            if (p < n - 1) push_low(h, p + 1);
        end
        push(1'b0, 1'b0, n, 1'b1);
        push(1'b0, 1'b0, n, 1'b0);
        push(1'b0, 1'b0, n, 1'b0);
    endtask

    task automatic drain_n(input int n);
        samp_t s;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            tick();
            s = q.pop_front();
            chk("pulse_out", 32'(bus.pulse_out), 32'(s.p));
            chk("busy",      32'(bus.busy),      32'(s.b));
            chk("pnumcnt",   32'(bus.pnumcnt),   32'(s.c));
            chk("done",      32'(bus.done),      32'(s.d));
        end
    endtask

    task automatic drain();
        drain_n(q.size());
    endtask

    function automatic int clamp(input int f);
        return (f < 2) ? 2 : f;
    endfunction

    initial begin
        int f;
        int n;
        checks   = 0;
        failures = 0;
        rst_n     = 1'b0;
        bus.freq  = 32'd0;
        bus.pnum  = 33'd0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.limit = 1'b0;
        #12;
        chk("rst_pulse", 32'(bus.pulse_out), 32'd0);
        chk("rst_busy",  32'(bus.busy),      32'd0);
        chk("rst_cnt",   32'(bus.pnumcnt),   32'd0);
        chk("rst_done",  32'(bus.done),      32'd0);
        rst_n = 1'b1;
        tick();

        // Load target 3 first, then start with h=4.
        bus.freq = 32'd4;
        bus.pnum = {1'b1, 32'd3};
        tick();
        bus.start = 1'b1;
        push_run(4, 3);
        drain();

        // freq=0 clamps to 2; load and start in the same cycle.
        bus.freq  = 32'd0;
        bus.pnum  = {1'b1, 32'd2};
        bus.start = 1'b1;
        push_run(2, 2);
        drain();

        // Continuous mode, stop during the 11th HIGH phase.
        bus.freq  = 32'd2;
        bus.pnum  = {1'b1, 32'd0};
        bus.start = 1'b1;
        for (int p = 0; p < 10; p++) begin
            push_high(2, p);
            push_low(2, p + 1);
        end
        push(1'b1, 1'b1, 10, 1'b0);
        drain();
        bus.stop = 1'b1;
        push(1'b0, 1'b0, 10, 1'b1);
        push(1'b0, 1'b0, 10, 1'b0);
        drain();

        // start with stop, then start with limit: nothing moves, no done.
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 10, 1'b0);
        drain();
        bus.start = 1'b1;
        bus.limit = 1'b1;
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 10, 1'b0);
        drain();
        bus.limit = 1'b0;

        // freq 3 -> 6 during the first LOW; the current LOW keeps 3.
        bus.freq  = 32'd3;
        bus.start = 1'b1;
        push_high(3, 0);
        push(1'b0, 1'b1, 1, 1'b0);
        drain();
        bus.freq = 32'd6;
        push(1'b0, 1'b1, 1, 1'b0);
        push(1'b0, 1'b1, 1, 1'b0);
        push_high(6, 1);
        push_low(6, 2);
        push(1'b1, 1'b1, 2, 1'b0);
        drain();
        bus.stop = 1'b1;
        push(1'b0, 1'b0, 2, 1'b1);
        drain();

        // limit asserted while running aborts like stop.
        f = int'($urandom_range(2, 5));
        bus.freq  = 32'(f);
        bus.start = 1'b1;
        push_high(f, 0);
        push_low(f, 1);
        push(1'b1, 1'b1, 1, 1'b0);
        drain();
        bus.limit = 1'b1;
        push(1'b0, 1'b0, 1, 1'b1);
        drain();
        bus.limit = 1'b0;
        push(1'b0, 1'b0, 1, 1'b0);
        drain();

        // Target 5; a load of 100 mid-run is ignored, and 5 is kept afterwards.
        bus.freq  = 32'd2;
        bus.pnum  = {1'b1, 32'd5};
        bus.start = 1'b1;
        push_run(2, 5);
        drain_n(3);
        bus.pnum = {1'b1, 32'd100};
        drain();
        bus.start = 1'b1;
        push_run(2, 5);
        drain();

        // Randomized runs: random half-period (clamping included) and target.
        for (int r = 0; r < 6; r++) begin
            f = int'($urandom_range(0, 6));
            n = int'($urandom_range(1, 4));
            bus.freq  = 32'(f);
            bus.pnum  = {1'b1, 32'(n)};
            bus.start = 1'b1;
            push_run(clamp(f), n);
            drain();
        end

        // Async reset mid-HIGH; the target (1) must be lost afterwards.
        bus.freq  = 32'd5;
        bus.pnum  = {1'b1, 32'd1};
        bus.start = 1'b1;
        push_high(2, 0);
        drain();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pulse", 32'(bus.pulse_out), 32'd0);
        chk("arst_busy",  32'(bus.busy),      32'd0);
        chk("arst_cnt",   32'(bus.pnumcnt),   32'd0);
        chk("arst_done",  32'(bus.done),      32'd0);
        rst_n = 1'b1;
        tick();
        bus.freq  = 32'd2;
        bus.start = 1'b1;
        push_high(2, 0);
        push_low(2, 1);
        push_high(2, 1);
        push_low(2, 2);
        push(1'b1, 1'b1, 2, 1'b0);
        drain();
        bus.stop = 1'b1;
        push(1'b0, 1'b0, 2, 1'b1);
        push(1'b0, 1'b0, 2, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
